// File: rtl/debounce_multi.sv
// Multi-channel button/switch debouncer: per-channel synchronizer, stability counter, level and edge pulses.
// Optional long-press detection is compiled in when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_multi #(
  parameter int els_p           = 4,
  parameter int stable_cycles_p = 1024,
  parameter int sync_stages_p   = 2
`ifdef DEBOUNCE_LONG_PRESS_EN
  , parameter int long_cycles_p = 65536
`endif
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [els_p-1:0] button_i,
  output logic [els_p-1:0] debounce_o,
  output logic [els_p-1:0] rise_o,
  output logic [els_p-1:0] fall_o
`ifdef DEBOUNCE_LONG_PRESS_EN
  , output logic [els_p-1:0] long_o
`endif
);

  localparam int cnt_width_lp = (stable_cycles_p + 1 > 1) ? $clog2(stable_cycles_p + 1) : 1;
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(stable_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int hold_width_lp = $clog2(long_cycles_p + 1);
  localparam logic [hold_width_lp-1:0] hold_last_lp = hold_width_lp'(long_cycles_p - 1);
  localparam logic [hold_width_lp-1:0] hold_max_lp  = hold_width_lp'(long_cycles_p);
  localparam logic [hold_width_lp-1:0] hold_one_lp  = hold_width_lp'(1);
`endif

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    logic [sync_stages_p-1:0] sync_q;
    logic [cnt_width_lp-1:0]  cnt_q;
    logic                     deb_q;
    logic                     rise_q;
    logic                     fall_q;
    logic                     sync;

    assign sync = sync_q[sync_stages_p-1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) sync_q <= '0;
      else            sync_q <= {sync_q[sync_stages_p-2:0], button_i[i]};
    end

    // Any cycle where sync agrees with the level restarts the window.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cnt_q  <= '0;
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == cnt_last_lp) begin
          cnt_q  <= '0;
          deb_q  <= sync;
          rise_q <= sync;
          fall_q <= ~sync;
        end else begin
          cnt_q <= cnt_q + cnt_one_lp;
        end
      end
    end

    assign debounce_o[i] = deb_q;
    assign rise_o[i]     = rise_q;
    assign fall_o[i]     = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    logic [hold_width_lp-1:0] hold_q;
    logic                     long_q;

    // Hold counter saturates at the threshold, so the pulse fires once per press.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else if (!deb_q) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= (hold_q == hold_last_lp);
        if (hold_q != hold_max_lp) hold_q <= hold_q + hold_one_lp;
      end
    end

    assign long_o[i] = long_q;
`endif
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Multi-channel, parametrised successor to the single-button debouncer.
- Each of els_p asynchronous inputs (buttons, switches) gets its own synchronizer, stability counter, debounced level and one-cycle rise/fall pulses.
- Sits between board I/O pins and the control/CSR logic on the FPGA top level.
- Stability window, synchronizer depth and channel count are independent parameters.

Parameters:
- els_p, 4, number of independent channels.
- stable_cycles_p, 1024, consecutive cycles a synchronized input must differ from the current debounced level before the level flips. Must be >= 1.
- sync_stages_p, 2, synchronizer flops per channel. Must be >= 2.
- cnt_width_lp (localparam), `BSG_SAFE_CLOG2(stable_cycles_p+1), width of each stability counter.

Ports:
- clk_i, input, 1, single clock for all logic.
- reset_n_i, input, 1, asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronized externally.
- button_i, input, els_p, raw asynchronous inputs, one bit per channel.
- debounce_o, output, els_p, debounced level per channel.
- rise_o, output, els_p, one-cycle pulse per channel when debounce_o goes 0->1.
- fall_o, output, els_p, one-cycle pulse per channel when debounce_o goes 1->0.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - all synchronizer flops, counters, debounce_o, rise_o and fall_o are 0 immediately;
  - no pulses are generated on reset exit.
- Channels are fully independent; no shared state between channels.
- Synchronizer: button_i[i] passes through sync_stages_p flops; sync[i] is the last stage.
- Per channel, each cycle:
  - if sync[i] == debounce_o[i]: counter <= 0.
  - else if counter == stable_cycles_p-1: debounce_o[i] <= sync[i]; counter <= 0; rise_o[i] or fall_o[i] <= 1 according to the new level.
  - else: counter <= counter+1.
- rise_o[i] and fall_o[i] are 0 in every cycle not named above. They are registered and are high in the same cycle as the new debounce_o value, for exactly one cycle. They are never both high.
- Latency:
  - button_i changes and then holds steady -> debounce_o changes sync_stages_p + stable_cycles_p clock edges later;
  - stable_cycles_p=1 gives a pure sync_stages_p+1 delay.
- Glitch rejection: any sync[i] return to debounce_o[i] before the window completes clears the counter. The window restarts from 0 on the next differing cycle.
- Counter never exceeds stable_cycles_p-1; no wrap-around is possible.
- Input toggling every cycle indefinitely -> debounce_o never changes and no pulses are generated.
- Reset mid-window: the counter is discarded; after reset the channel starts from level 0.
- An input already high at reset exit produces a normal rise_o after sync_stages_p + stable_cycles_p cycles.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- When defined:
  - adds parameter long_cycles_p (default 65536, > stable_cycles_p) and output long_o [els_p];
  - a per-channel saturating hold counter increments every cycle debounce_o[i]=1 and clears when debounce_o[i]=0;
  - long_o[i] pulses for exactly one cycle when the hold counter reaches long_cycles_p;
  - it does not pulse again until after the next fall_o[i].
- When undefined: no long_o port, no hold counters, no extra logic.

Test Plan:
- Reset/static (els_p=4, stable=8, sync=2): hold reset_n_i=0 with button_i=4'hF, then release -> outputs 0 during reset; debounce_o=4'hF exactly 10 cycles after release; rise_o=4'hF for 1 cycle; fall_o stays 0.
- Clean press then release on ch1: button_i[1] 0->1 at cycle 0, 1->0 at cycle 40 -> debounce_o[1] rises at cycle 10 and falls at cycle 50; single rise_o[1]/fall_o[1] pulses; other channels stay 0.
- Glitch rejection on ch0: apply a 7-cycle high pulse (one short of stable=8) -> no change, no pulses. Repeat with an 8-cycle pulse -> debounce_o[0] high for 8 cycles, rise then fall pulse.
- Bounce: ch2 toggles every 3 cycles for 60 cycles, then holds 1 -> debounce_o[2] stays 0 throughout bouncing and rises 10 cycles after the final edge.
- Async reset mid-window: assert reset_n_i between clock edges at counter=5 while debounce_o=4'h3 -> all outputs 0 before the next edge; no pulses after release.
- DEBOUNCE_LONG_PRESS_EN with long_cycles_p=32: hold ch3 high for 100 cycles -> long_o[3] pulses once, 32 cycles after rise_o[3]; re-press yields a fresh pulse.
